spike_rate_decoder: RTL and testbench

Windowed rate decoder for spike trains, the receiving end of the integrate-and-fire neuron layers. Over a fixed window of `WINDOW` clock cycles it counts spikes on each of `CHANNELS` input lines. It then presents the per-channel counts and the index of the most active channel (winner-take-all) on a valid/ready output port. It sits after the output neuron layer and turns spike activity back into binary values for the chip outputs or the host.

---
 rtl/spike_rate_decoder.sv | 143 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a fixed window of WINDOW
// cycles. It then presents the per-channel counts and the winning (most active)
// channel on a valid/ready port.
// Optional feature: define SPIKE_DECODER_AUTORESTART_EN to let a window end
// roll straight into the next window when start is held high. An unaccepted
// result overwritten this way raises the sticky overrun flag.
module spike_rate_decoder #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 8,
    parameter int WINDOW   = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CHANNELS-1:0]       spike_in,
    output logic [CHANNELS*CNT_W-1:0] count_out,
    output logic [2:0]                winner,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      overrun
);

    typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

    state_t                     state;
    state_t                     state_next;
    logic [15:0]                win_cnt;
    logic [CNT_W-1:0]           cnt [CHANNELS];
    logic [CHANNELS*CNT_W-1:0]  cnt_next;
    logic                       win_end;
    logic                       transfer;
    logic                       restart;
    logic                       clear;

    // Saturating increment: a full counter holds its value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // Winner-take-all: only a strictly greater count displaces the current
    // best, so ties resolve to the lowest index and all-zero gives channel 0.
    function automatic logic [2:0] pick_winner(input logic [CHANNELS*CNT_W-1:0] c);
        logic [CNT_W-1:0] best;
        logic [2:0]       idx;
        best = c[0 +: CNT_W];
        idx  = 3'd0;
        for (int i = 1; i < CHANNELS; i++) begin
            if (c[i*CNT_W +: CNT_W] > best) begin
                best = c[i*CNT_W +: CNT_W];
                idx  = 3'(i);
            end
        end
        return idx;
    endfunction

    assign win_end  = (state == COUNT) && (win_cnt == 16'(WINDOW - 1));
    assign transfer = out_valid && out_ready;
    assign busy     = (state == COUNT);

`ifdef SPIKE_DECODER_AUTORESTART_EN
    assign restart = win_end && start;
`else
    assign restart = 1'b0;
`endif

    // A new window begins from IDLE, from a HOLD transfer with start, or on restart.
    assign clear = ((state == IDLE) && start) ||
                   ((state == HOLD) && transfer && start) ||
                   restart;

    // Counter values after this edge's spikes, used both to advance and to latch.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < CHANNELS; i++)
            cnt_next[i*CNT_W +: CNT_W] = sat_inc(cnt[i], spike_in[i]);
    end

    // Next-state logic for the IDLE / COUNT / HOLD sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COUNT;
            COUNT:   if (win_end && !restart) state_next = HOLD;
            HOLD:    if (transfer) state_next = start ? COUNT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any window in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Spike and window counters; cleared at every window start before use.
    always_ff @(posedge clk) begin
        if (clear) begin
            win_cnt <= '0;
            for (int i = 0; i < CHANNELS; i++)
                cnt[i] <= '0;
        end else if (state == COUNT) begin
            win_cnt <= win_cnt + 16'd1;
            for (int i = 0; i < CHANNELS; i++)
                cnt[i] <= cnt_next[i*CNT_W +: CNT_W];
        end
    end

    // Result port: latch counts and winner at window end, drop valid on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_out <= '0;
            winner    <= 3'd0;
            out_valid <= 1'b0;
        end else if (win_end) begin
            count_out <= cnt_next;
            winner    <= pick_winner(cnt_next);
            out_valid <= 1'b1;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SPIKE_DECODER_AUTORESTART_EN
    // Sticky overrun: set when a pending result is replaced without a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (transfer)
            overrun <= 1'b0;
        else if (win_end && out_valid)
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Testbench for spike_rate_decoder: directed spike patterns with hand-computed
// counts, checked by per-instance scoreboards on every result transfer.
// Instance A: CNT_W=8, WINDOW=16. Instance B: CNT_W=4, WINDOW=32 (saturation).
// The autorestart scenario runs when SPIKE_DECODER_AUTORESTART_EN is defined.
module tb_spike_rate_decoder;

    typedef struct {
        logic [31:0] m0;
        logic [31:0] m1;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [2:0]  w;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, out_ready_a, out_valid_a, busy_a, overrun_a;
    logic [1:0]  spike_a;
    logic [15:0] count_a;
    logic [2:0]  winner_a;
    logic        start_b, out_ready_b, out_valid_b, busy_b, overrun_b;
    logic [1:0]  spike_b;
    logic [7:0]  count_b;
    logic [2:0]  winner_b;

    int   checks = 0;
    int   errors = 0;
    vec_t q_a[$];
    vec_t q_b[$];
    vec_t va[5];
    vec_t vb[4];

    always #5 clk = ~clk;

    spike_rate_decoder #(.CHANNELS(2), .CNT_W(8), .WINDOW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .spike_in(spike_a),
        .count_out(count_a), .winner(winner_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .busy(busy_a), .overrun(overrun_a)
    );

    spike_rate_decoder #(.CHANNELS(2), .CNT_W(4), .WINDOW(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .spike_in(spike_b),
        .count_out(count_b), .winner(winner_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .busy(busy_b), .overrun(overrun_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for A: compare the presented result on each transfer.
    always @(negedge clk) begin : mon_a
        vec_t e;
        if (rst_n && out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_result actual=%0h expected=none", count_a);
            end else begin
                e = q_a.pop_front();
                chk("a_count0", 32'(count_a[7:0]), 32'(e.c0));
                chk("a_count1", 32'(count_a[15:8]), 32'(e.c1));
                chk("a_winner", 32'(winner_a), 32'(e.w));
            end
        end
    end

    // Scoreboard for B.
    always @(negedge clk) begin : mon_b
        vec_t e;
        if (rst_n && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_result actual=%0h expected=none", count_b);
            end else begin
                e = q_b.pop_front();
                chk("b_count0", 32'(count_b[3:0]), 32'(e.c0));
                chk("b_count1", 32'(count_b[7:4]), 32'(e.c1));
                chk("b_winner", 32'(winner_b), 32'(e.w));
            end
        end
    end

    // Start edge for A; spikes on this edge must not be counted.
    task automatic begin_a();
        start_a = 1'b1;
        spike_a = 2'b11;
        tick();
        start_a = 1'b0;
        chk("a_busy_after_start", 32'(busy_a), 32'd1);
    endtask

    // Drive the 16 sampled edges of A's window and check result timing.
    task automatic count_win_a(input logic [31:0] m0, input logic [31:0] m1);
        for (int k = 0; k < 16; k++) begin
            spike_a = {m1[k], m0[k]};
            tick();
            if (k == 14) chk("a_valid_early", 32'(out_valid_a), 32'd0);
        end
        spike_a = 2'b00;
        chk("a_valid_at_end", 32'(out_valid_a), 32'd1);
        chk("a_busy_at_end", 32'(busy_a), 32'd0);
    endtask

    task automatic run_b(input vec_t v);
        q_b.push_back(v);
        start_b = 1'b1;
        spike_b = 2'b11;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 32; k++) begin
            spike_b = {v.m1[k], v.m0[k]};
            tick();
            if (k == 30) chk("b_valid_early", 32'(out_valid_b), 32'd0);
        end
        spike_b = 2'b00;
        chk("b_valid_at_end", 32'(out_valid_b), 32'd1);
    endtask

    initial begin
        va[0] = '{32'hFFFF, 32'h5555, 8'd16, 8'd8,  3'd0};
        va[1] = '{32'h0000, 32'h0000, 8'd0,  8'd0,  3'd0};
        va[2] = '{32'h000F, 32'h00FF, 8'd4,  8'd8,  3'd1};
        va[3] = '{32'h0F0F, 32'hF0F0, 8'd8,  8'd8,  3'd0};
        va[4] = '{32'h0000, 32'h8000, 8'd0,  8'd1,  3'd1};
        vb[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'd15, 8'd15, 3'd0};
        vb[1] = '{32'hFFFFFFFF, 32'h00003FFF, 8'd15, 8'd14, 3'd0};
        vb[2] = '{32'h00003FFF, 32'hFFFFFFFF, 8'd14, 8'd15, 3'd1};
        vb[3] = '{32'h0000000F, 32'h00000007, 8'd4,  8'd3,  3'd0};

        // Reset with random inputs.
        rst_n       = 1'b0;
        start_a     = 1'($urandom);
        spike_a     = 2'($urandom);
        out_ready_a = 1'($urandom);
        start_b     = 1'($urandom);
        spike_b     = 2'($urandom);
        out_ready_b = 1'($urandom);
        repeat (3) tick();
        chk("rst_count_a", 32'(count_a), 32'd0);
        chk("rst_winner_a", 32'(winner_a), 32'd0);
        chk("rst_valid_a", 32'(out_valid_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_overrun_a", 32'(overrun_a), 32'd0);
        chk("rst_valid_b", 32'(out_valid_b), 32'd0);
        start_a = 1'b0; spike_a = 2'b00; out_ready_a = 1'b1;
        start_b = 1'b0; spike_b = 2'b00; out_ready_b = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_outputs_a", {count_a, 3'(winner_a), out_valid_a, busy_a, overrun_a}, 32'd0);
        end

        // Directed windows on A, back to back (start together with transfer).
        for (int i = 0; i < 5; i++) begin
            q_a.push_back(va[i]);
            begin_a();
            count_win_a(va[i].m0, va[i].m1);
        end
        tick();

        // Back-pressure: result must hold and start must be ignored.
        out_ready_a = 1'b0;
        q_a.push_back('{32'h00FF, 32'hFFFF, 8'd8, 8'd16, 3'd1});
        begin_a();
        count_win_a(32'h00FF, 32'hFFFF);
        for (int i = 0; i < 10; i++) begin
            start_a = (i == 4 || i == 5);
            tick();
            chk("bp_valid", 32'(out_valid_a), 32'd1);
            chk("bp_busy", 32'(busy_a), 32'd0);
            chk("bp_hold", {13'd0, winner_a, count_a}, {13'd0, 3'd1, 16'h1008});
        end
        out_ready_a = 1'b1;
        q_a.push_back('{32'hFFFF, 32'h0000, 8'd16, 8'd0, 3'd0});
        begin_a();
        chk("bp_valid_dropped", 32'(out_valid_a), 32'd0);
        count_win_a(32'hFFFF, 32'h0000);
        tick();

        // Reset at window cycle 7: no result from the aborted window.
        start_a = 1'b1;
        spike_a = 2'b11;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_count", 32'(count_a), 32'd0);
        tick();
        rst_n = 1'b1;
        spike_a = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_result", 32'(out_valid_a), 32'd0);
        end
        q_a.push_back('{32'h0000, 32'h0007, 8'd0, 8'd3, 3'd1});
        begin_a();
        count_win_a(32'h0000, 32'h0007);
        tick();

        // Saturation and ties on B.
        for (int i = 0; i < 4; i++) run_b(vb[i]);
        tick();

`ifdef SPIKE_DECODER_AUTORESTART_EN
        // Autorestart with out_ready low: second window end overwrites.
        out_ready_a = 1'b0;
        start_a = 1'b1;
        spike_a = 2'b00;
        tick();
        for (int k = 0; k < 48; k++) begin
            start_a = (k < 32);
            if (k < 16)      spike_a = 2'b01;
            else if (k < 32) spike_a = 2'b10;
            else             spike_a = {(k - 32) < 5, (k - 32) < 3};
            tick();
            if (k == 15) begin
                chk("ar_w1_valid", 32'(out_valid_a), 32'd1);
                chk("ar_w1_overrun", 32'(overrun_a), 32'd0);
                chk("ar_w1_busy", 32'(busy_a), 32'd1);
                chk("ar_w1_count", 32'(count_a), 32'h0010);
            end
            if (k == 31) begin
                chk("ar_w2_overrun", 32'(overrun_a), 32'd1);
                chk("ar_w2_valid", 32'(out_valid_a), 32'd1);
                chk("ar_w2_count", 32'(count_a), 32'h1000);
            end
        end
        spike_a = 2'b00;
        chk("ar_w3_valid", 32'(out_valid_a), 32'd1);
        chk("ar_w3_busy", 32'(busy_a), 32'd0);
        chk("ar_w3_count", 32'(count_a), 32'h0503);
        q_a.push_back('{32'h0, 32'h0, 8'd3, 8'd5, 3'd1});
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        chk("ar_overrun_cleared", 32'(overrun_a), 32'd0);
        chk("ar_valid_cleared", 32'(out_valid_a), 32'd0);
        tick();
`endif

        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
